// File: rtl/fma_dot_sequencer_if.sv
// Handshake and datapath bundle between the operand feeder, the dot-product
// sequencer and the shared 8-bit FMA unit.
interface fma_dot_sequencer_if #(
  parameter int LEN_W = 8
);
  // command
  logic             start;
  logic [LEN_W-1:0] len;
  logic [7:0]       init_acc;
  logic             signed_mode;
  logic             abort;
  logic             busy;
  // operand stream
  logic             op_valid;
  logic             op_ready;
  logic [7:0]       op_b;
  logic [7:0]       op_c;
  // shared FMA unit
  logic [7:0]       fma_a;
  logic [7:0]       fma_b;
  logic [7:0]       fma_c;
  logic             fma_signed;
  logic [7:0]       fma_result;
  // result stream
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;

  // Environment side: issues commands, feeds operands, hosts the FMA, consumes results.
  modport master (
    output start, len, init_acc, signed_mode, abort,
    output op_valid, op_b, op_c, fma_result, res_ready,
    input  busy, op_ready, fma_a, fma_b, fma_c, fma_signed, res_valid, res_data
  );

  // Sequencer side.
  modport slave (
    input  start, len, init_acc, signed_mode, abort,
    input  op_valid, op_b, op_c, fma_result, res_ready,
    output busy, op_ready, fma_a, fma_b, fma_c, fma_signed, res_valid, res_data
  );
endinterface

// File: rtl/fma_dot_sequencer.sv
// Dot-product sequencer: drives one shared FMA unit with the running
// accumulator as summand, consuming one operand pair per accepted beat, and
// returns the wrapped 8-bit sum on a valid/ready result port.
module fma_dot_sequencer #(
  parameter int LEN_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  fma_dot_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [7:0]       acc_r;
  logic [LEN_W-1:0] cnt_r;
  logic             sign_r;
  logic             xfer_s;
  logic             last_beat_s;
  logic             busy_s;
  logic             op_ready_s;
  logic             res_valid_s;

  // A beat transfers only in RUN; abort suppresses it so nothing is counted.
  assign xfer_s      = (state_r == ST_RUN) && bus.op_valid && !bus.abort;
  assign last_beat_s = (cnt_r == LEN_W'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort outranks both operand transfer and result handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt_s = (bus.len == LEN_W'(0)) ? ST_DONE : ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_nxt_s = ST_IDLE;
        end else if (xfer_s && last_beat_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.abort || bus.res_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Accumulator, remaining-beat counter and signedness latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r  <= 8'h00;
      cnt_r  <= LEN_W'(0);
      sign_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && bus.start) begin
      acc_r  <= bus.init_acc;
      cnt_r  <= bus.len;
      sign_r <= bus.signed_mode;
    end else if (xfer_s) begin
      acc_r  <= bus.fma_result;
      cnt_r  <= cnt_r - LEN_W'(1);
    end else begin
      acc_r  <= acc_r;
      cnt_r  <= cnt_r;
      sign_r <= sign_r;
    end
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    busy_s      = 1'b0;
    op_ready_s  = 1'b0;
    res_valid_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_s = 1'b0;
      end
      ST_RUN: begin
        busy_s     = 1'b1;
        op_ready_s = 1'b1;
      end
      ST_DONE: begin
        busy_s      = 1'b1;
        res_valid_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  assign bus.busy       = busy_s;
  assign bus.op_ready   = op_ready_s;
  assign bus.res_valid  = res_valid_s;
  assign bus.res_data   = acc_r;
  assign bus.fma_a      = acc_r;
  assign bus.fma_b      = bus.op_b;
  assign bus.fma_c      = bus.op_c;
  assign bus.fma_signed = sign_r;

endmodule

// File: tb/tb_fma_dot_sequencer.sv
// Self-checking bench for fma_dot_sequencer with a behavioural FMA unit and a
// dot-product reference model computed from recorded operand queues.
module tb_fma_dot_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  fma_dot_sequencer_if #(.LEN_W(8)) bus ();

  fma_dot_sequencer #(.LEN_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural shared FMA unit: a + b[3:0]*c[3:0] mod 256.
  assign bus.fma_result = 8'((int'(bus.fma_a) + (int'(bus.fma_b) % 16) * (int'(bus.fma_c) % 16)) % 256);

  // Reference: initial value plus sum of low-nibble products, wrapped to 8 bits.
  function automatic logic [7:0] dot_ref(input logic [7:0] init, input logic [7:0] bq[$], input logic [7:0] cq[$]);
    int s;
    s = int'(init);
    foreach (bq[i]) s = s + (int'(bq[i]) % 16) * (int'(cq[i]) % 16);
    return 8'(s % 256);
  endfunction

  // Runs one command with random operands; reports what the DUT did.
  task automatic run_vec(input int n, input logic [7:0] init, input logic sm, input int gap_pct,
                         input int stall, input bit noisy,
                         output int beats, output logic [7:0] got, output logic [7:0] expv,
                         output bit lat_ok, output bit hold_ok, output bit sign_ok,
                         output bit idle_ok, output bit tmo);
    logic [7:0] bq[$];
    logic [7:0] cq[$];
    logic [7:0] b, c;
    int cyc, last;
    beats = 0; hold_ok = 1'b1; sign_ok = 1'b1; idle_ok = 1'b1; cyc = 0; last = -1;
    @(negedge clk);
    bus.start = 1'b1; bus.len = 8'(n); bus.init_acc = init; bus.signed_mode = sm; bus.op_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    while (bus.res_valid !== 1'b1 && cyc < 300) begin
      if (bus.fma_signed !== sm) sign_ok = 1'b0;
      b = 8'($urandom); c = 8'($urandom);
      bus.op_b = b; bus.op_c = c;
      if (bus.op_ready === 1'b1 && int'($urandom_range(99)) >= gap_pct) begin
        bus.op_valid = 1'b1; bq.push_back(b); cq.push_back(c); beats++; last = cyc;
      end else begin
        bus.op_valid = 1'b0;
      end
      if (noisy) begin
        bus.signed_mode = 1'($urandom);
        bus.start = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    bus.op_valid = 1'b0; bus.start = 1'b0;
    tmo    = (bus.res_valid !== 1'b1);
    lat_ok = (n == 0) ? (cyc == 0) : (cyc == last + 1);
    expv   = dot_ref(init, bq, cq);
    got    = bus.res_data;
    bus.res_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      if (noisy) bus.start = 1'($urandom);
      @(negedge clk);
      if (bus.res_valid !== 1'b1 || bus.res_data !== got) hold_ok = 1'b0;
    end
    bus.res_ready = 1'b1;
    bus.start = noisy ? 1'b1 : 1'b0;
    @(negedge clk);
    if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) idle_ok = 1'b0;
    bus.res_ready = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    if (bus.busy !== 1'b0) idle_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    checks++; if (bus.op_ready !== 1'b0) begin errors++; $display("FAIL reset_op_ready got %0b want 0", bus.op_ready); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %0b want 0", bus.res_valid); end
    checks++; if (bus.res_data !== 8'h00) begin errors++; $display("FAIL reset_res_data got %h want 00", bus.res_data); end
    checks++; if (bus.fma_signed !== 1'b0) begin errors++; $display("FAIL reset_fma_signed got %0b want 0", bus.fma_signed); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] bs[3];
    logic [7:0] cs[3];
    bs = '{8'd2, 8'd4, 8'd1};
    cs = '{8'd3, 8'd5, 8'd1};
    @(negedge clk);
    bus.start = 1'b1; bus.len = 8'd3; bus.init_acc = 8'h00; bus.signed_mode = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("FAIL basic_op_ready beat %0d got %0b want 1", i, bus.op_ready); end
      bus.op_valid = 1'b1; bus.op_b = bs[i]; bus.op_c = cs[i];
      @(negedge clk);
    end
    bus.op_valid = 1'b0;
    checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL basic_res_valid got %0b want 1", bus.res_valid); end
    checks++; if (bus.res_data !== 8'h1B) begin errors++; $display("FAIL basic_res_data got %h want 1b", bus.res_data); end
    checks++; if (bus.op_ready !== 1'b0) begin errors++; $display("FAIL basic_op_ready_done got %0b want 0", bus.op_ready); end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_idle got busy %0b want 0", bus.busy); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    bus.start = 1'b1; bus.len = 8'd1; bus.init_acc = 8'hF0; bus.signed_mode = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.signed_mode = 1'b0;
    bus.op_valid = 1'b1; bus.op_b = 8'h1F; bus.op_c = 8'h12;
    #1;
    checks++; if (bus.fma_a !== 8'hF0) begin errors++; $display("FAIL wrap_fma_a got %h want f0", bus.fma_a); end
    checks++; if (bus.fma_b !== 8'h1F || bus.fma_c !== 8'h12) begin errors++; $display("FAIL wrap_fma_bc got %h/%h want 1f/12", bus.fma_b, bus.fma_c); end
    checks++; if (bus.fma_signed !== 1'b1) begin errors++; $display("FAIL wrap_fma_signed got %0b want 1", bus.fma_signed); end
    @(negedge clk);
    bus.op_valid = 1'b0;
    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h0E) begin errors++; $display("FAIL wrap_result got v%0b %h want v1 0e", bus.res_valid, bus.res_data); end
    checks++; if (bus.fma_signed !== 1'b1) begin errors++; $display("FAIL wrap_sign_hold got %0b want 1", bus.fma_signed); end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic test_zero_len();
    int beats; logic [7:0] got, expv; bit lat_ok, hold_ok, sign_ok, idle_ok, tmo;
    run_vec(0, 8'h55, 1'b0, 0, 0, 1'b0, beats, got, expv, lat_ok, hold_ok, sign_ok, idle_ok, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL zero_timeout got no res_valid want res_valid"); end
    checks++; if (beats !== 0) begin errors++; $display("FAIL zero_beats got %0d want 0", beats); end
    checks++; if (got !== 8'h55) begin errors++; $display("FAIL zero_res_data got %h want 55", got); end
    checks++; if (!lat_ok) begin errors++; $display("FAIL zero_latency got late want next cycle"); end
    checks++; if (!idle_ok) begin errors++; $display("FAIL zero_idle got busy want idle"); end
  endtask

  task automatic test_stall();
    int beats; logic [7:0] got, expv; bit lat_ok, hold_ok, sign_ok, idle_ok, tmo;
    run_vec(4, 8'($urandom), 1'b1, 50, 3, 1'b1, beats, got, expv, lat_ok, hold_ok, sign_ok, idle_ok, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL stall_timeout got no res_valid want res_valid"); end
    checks++; if (beats !== 4) begin errors++; $display("FAIL stall_beats got %0d want 4", beats); end
    checks++; if (got !== expv) begin errors++; $display("FAIL stall_res_data got %h want %h", got, expv); end
    checks++; if (!hold_ok) begin errors++; $display("FAIL stall_hold got unstable want stable"); end
    checks++; if (!sign_ok) begin errors++; $display("FAIL stall_sign got changed want latched 1"); end
    checks++; if (!lat_ok) begin errors++; $display("FAIL stall_latency got wrong want 1 cycle"); end
    checks++; if (!idle_ok) begin errors++; $display("FAIL stall_idle got busy want idle"); end
  endtask

  task automatic test_abort();
    bit seen;
    @(negedge clk);
    bus.start = 1'b1; bus.len = 8'd4; bus.init_acc = 8'h11;
    @(negedge clk);
    bus.start = 1'b0; bus.op_valid = 1'b1; bus.op_b = 8'h23; bus.op_c = 8'h45;
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0; bus.op_valid = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_run_idle got busy %0b want 0", bus.busy); end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL abort_no_result got res_valid 1 want 0"); end
    // abort in DONE drops the result
    bus.start = 1'b1; bus.len = 8'd0; bus.init_acc = 8'h77;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL abort_done got v%0b busy%0b want 0 0", bus.res_valid, bus.busy); end
    // abort with start in IDLE: start wins
    bus.start = 1'b1; bus.abort = 1'b1; bus.len = 8'd0; bus.init_acc = 8'h3C;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h3C) begin errors++; $display("FAIL abort_start_idle got v%0b %h want v1 3c", bus.res_valid, bus.res_data); end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int beats; logic [7:0] got, expv; bit lat_ok, hold_ok, sign_ok, idle_ok, tmo;
    @(negedge clk);
    bus.start = 1'b1; bus.len = 8'd4; bus.init_acc = 8'hA5; bus.signed_mode = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.op_valid = 1'b1; bus.op_b = 8'h37; bus.op_c = 8'h29;
    @(negedge clk);
    bus.op_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.op_ready !== 1'b0 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl got %0b%0b%0b want 000", bus.busy, bus.op_ready, bus.res_valid); end
    checks++; if (bus.res_data !== 8'h00 || bus.fma_a !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h/%h want 00/00", bus.res_data, bus.fma_a); end
    checks++; if (bus.fma_signed !== 1'b0) begin errors++; $display("FAIL rstmid_sign got %0b want 0", bus.fma_signed); end
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(4, 8'($urandom), 1'b0, 20, 1, 1'b0, beats, got, expv, lat_ok, hold_ok, sign_ok, idle_ok, tmo);
    checks++; if (tmo || beats !== 4) begin errors++; $display("FAIL rstmid_after_beats got %0d tmo %0b want 4", beats, tmo); end
    checks++; if (got !== expv) begin errors++; $display("FAIL rstmid_after_data got %h want %h", got, expv); end
  endtask

  task automatic test_random();
    int beats, n; logic [7:0] got, expv; bit lat_ok, hold_ok, sign_ok, idle_ok, tmo;
    for (int k = 0; k < 25; k++) begin
      n = int'($urandom_range(10));
      run_vec(n, 8'($urandom), 1'($urandom), int'($urandom_range(60)), int'($urandom_range(3)),
              1'($urandom), beats, got, expv, lat_ok, hold_ok, sign_ok, idle_ok, tmo);
      checks++; if (tmo || beats !== n) begin errors++; $display("FAIL rand_beats iter %0d got %0d want %0d", k, beats, n); end
      checks++; if (got !== expv) begin errors++; $display("FAIL rand_res_data iter %0d got %h want %h", k, got, expv); end
      checks++; if (!(lat_ok && hold_ok && sign_ok && idle_ok)) begin errors++; $display("FAIL rand_protocol iter %0d got lat%0b hold%0b sign%0b idle%0b want 1111", k, lat_ok, hold_ok, sign_ok, idle_ok); end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.len = 8'd0; bus.init_acc = 8'h00; bus.signed_mode = 1'b0;
    bus.abort = 1'b0; bus.op_valid = 1'b0; bus.op_b = 8'h00; bus.op_c = 8'h00;
    bus.res_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_zero_len();
    test_stall();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fma_dot_sequencer.md
Name: fma_dot_sequencer

Overview:
Controller that sequences one shared 8-bit FMA unit (result = a + b[3:0]*c[3:0], mod 256) through a dot-product of programmable length. It accepts a command, streams operand pairs through a valid/ready port, feeds the running accumulator back as the FMA summand each cycle, and returns the final 8-bit value on a valid/ready result port. It sits between the TPU operand feeder and the MAC datapath.

Parameters:
LEN_W, 8, width of the element-count field; max vector length 2^LEN_W-1.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  command strobe; sampled only in IDLE
len  in  LEN_W  number of operand pairs for this command
init_acc  in  8  starting accumulator value
signed_mode  in  1  signedness flag forwarded to the FMA
abort  in  1  synchronous cancel of the current command
busy  out  1  high whenever state != IDLE
op_valid  in  1  operand pair valid
op_ready  out  1  sequencer accepts operand pair
op_b  in  8  operand b
op_c  in  8  operand c
fma_a  out  8  FMA summand (= accumulator register)
fma_b  out  8  FMA b (= op_b, combinational)
fma_c  out  8  FMA c (= op_c, combinational)
fma_signed  out  1  latched signed_mode
fma_result  in  8  combinational FMA result
res_valid  out  1  result valid
res_ready  in  1  result consumer ready
res_data  out  8  final accumulator value

Behaviour:
- Async reset (rst_n=0): state=IDLE, acc=0x00, cnt=0, sign latch=0; busy=0, op_ready=0, res_valid=0, res_data=0x00. Takes effect immediately, including mid-command; no partial result is emitted.
- States: IDLE, RUN, DONE.
- IDLE: op_ready=0, res_valid=0. On start=1: acc<=init_acc, sign latch<=signed_mode, cnt<=len. If len!=0 -> RUN; if len==0 -> DONE (result = init_acc, no operands consumed).
- RUN: op_ready=1. A beat transfers when op_valid & op_ready. On transfer: acc<=fma_result, cnt<=cnt-1; if cnt==1 -> DONE. No transfer: hold all state. Throughput 1 pair/cycle.
- DONE: res_valid=1, res_data=acc, op_ready=0. On res_ready=1 -> IDLE. res_data stable while res_valid=1 & res_ready=0.
- Latency: res_valid rises the cycle after the last pair transfers (or the cycle after start when len==0).
- Arithmetic: fma_result is taken as-is; sequencer adds no width extension, saturation or overflow detection; accumulation wraps mod 256.
- fma_a/fma_b/fma_c/fma_signed are driven in all states; FMA output ignored outside RUN transfers.
- start while busy=1: ignored, no effect on cnt/acc.
- abort=1 in RUN or DONE: next state IDLE, no transfer counted that cycle, res_valid drops; abort has priority over op transfer and res_ready. abort in IDLE: ignored; abort and start together in IDLE: start wins.
- Same-cycle DONE handshake and start: start not seen (state not IDLE); new command accepted earliest the cycle after returning to IDLE.

Test Plan:
- init_acc=0x00, len=3, pairs (2,3),(4,5),(1,1) back-to-back -> op_ready high 3 cycles, res_valid 1 cycle after 3rd beat, res_data=0x1B.
- init_acc=0xF0, len=1, op_b=0x1F, op_c=0x12 -> fma sees b/c nibbles F,2; res_data=0x0E (wrap); fma_signed follows signed_mode latched at start even if signed_mode toggles in RUN.
- start with len=0, init_acc=0x55 -> op_ready never asserts, res_valid next cycle with res_data=0x55; res_ready=1 -> IDLE, busy=0.
- len=4, op_valid gaps (1,0,1,0,1,1), res_ready low 3 cycles, start pulsed during RUN/DONE -> exactly 4 beats counted, res_data held constant while stalled, extra start ignored.
- len=4, abort after 1st beat -> IDLE next cycle, res_valid never high; repeat with rst_n=0 pulse mid-RUN -> all outputs 0 immediately, new command after release gives correct result.
